axi_mem_responder: RTL and testbench
====================================

# axi_mem_responder

AXI4 slave (responder) that terminates the 64-bit AXI master port of the FPGA core wrapper and backs it with an on-chip memory. It serves the core's boot/program RAM in FPGA builds without a vendor interconnect. It handles FIXED, INCR and WRAP bursts with one outstanding transaction at a time, arbitrating between the read and write channels.

## Interface
- `MEM_WORDS`, 16384: memory depth in 64-bit words (power of two); 128 KiB by default.
- `BASE_ADDR`, 64'h8000_0000: byte address of word 0.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. Asynchronous, active-low. Single clock domain.
- `S_AXI_AWID`/`AWADDR`/`AWLEN`/`AWSIZE`/`AWBURST` in 4/64/8/3/2: write address channel.
- `S_AXI_AWLOCK`/`AWCACHE`/`AWPROT`/`AWQOS` in 1/4/3/4: accepted and ignored.
- `S_AXI_AWVALID` in 1; `S_AXI_AWREADY` out 1.
- `S_AXI_WDATA`/`WSTRB`/`WLAST` in 64/8/1; `S_AXI_WVALID` in 1; `S_AXI_WREADY` out 1.
- `S_AXI_BID` out 4, `S_AXI_BRESP` out 2, `S_AXI_BVALID` out 1, `S_AXI_BREADY` in 1.
- `S_AXI_ARID`/`ARADDR`/`ARLEN`/`ARSIZE`/`ARBURST` in 4/64/8/3/2; `ARLOCK`/`ARCACHE`/`ARPROT`/`ARQOS` in, ignored.
- `S_AXI_ARVALID` in 1; `S_AXI_ARREADY` out 1.
- `S_AXI_RID` out 4, `S_AXI_RDATA` out 64, `S_AXI_RRESP` out 2, `S_AXI_RLAST` out 1, `S_AXI_RVALID` out 1, `S_AXI_RREADY` in 1.

## Operation
- FSM states: IDLE, WR_DATA, WR_RESP, RD_ISSUE, RD_DATA.
- IDLE: AWREADY/ARREADY asserted only here, and only for the granted channel. If only one VALID is set, grant it. If both are set, grant the channel not granted last. After reset, read wins.
- On AW handshake, latch id, addr, len, size and burst, clear the error flag, and go to WR_DATA.
- WR_DATA: WREADY=1. Each beat writes bytes by WSTRB to word `(addr-BASE_ADDR)>>3` if the address is in range. If out of range, no write and the error flag is set. The address advances per burst rules. After the beat with beat count == len, go to WR_RESP. WLAST is not used for sequencing.
- WR_RESP: BVALID=1, BID=latched id, BRESP=SLVERR(2'b10) if the error flag is set, else OKAY. On BREADY, go to IDLE.
- On AR handshake, latch id, addr, len, size and burst, and go to RD_ISSUE.
- RD_ISSUE: present the address to the synchronous RAM and go to RD_DATA.
- RD_DATA: RVALID=1. RDATA=RAM output, registered and held stable while stalled. RRESP is per beat: SLVERR with RDATA=0 if out of range. RLAST=(beat count == len).
- On RREADY: if it was the last beat, go to IDLE; else advance the address and go to RD_ISSUE.
- Address arithmetic (64-bit):
  - step = 1<<size.
  - FIXED: address is unchanged.
  - INCR: addr+step.
  - WRAP: total = (len+1)<<size and base = addr & ~(total-1). The next address is base | ((addr+step) & (total-1)).
  - A reserved burst (2'b11) is treated as INCR.
- In range means `BASE_ADDR <= addr < BASE_ADDR + MEM_WORDS*8`. Address bits [2:0] are ignored for indexing.
- Exclusive access is unsupported; lock is ignored and the response is never EXOKAY.

## Timing
- Reset values:
  - All READY and VALID outputs: 0.
  - BID, RID, BRESP, RRESP, RLAST: 0.
  - RDATA: 0.
  - FSM: IDLE; last-grant flag: write (so read wins next).
- Memory contents are not reset.
- Address handshake to first W acceptance: 1 cycle. Writes run at 1 beat/cycle. BVALID rises the cycle after the last W handshake.
- Read: AR handshake → RVALID after 2 cycles (RD_ISSUE, then RD_DATA). Throughput is 1 beat per 2 cycles.
- The next address handshake is accepted in the cycle after B or the final R handshake.
- Outputs in RD_DATA and WR_RESP stay stable until READY, as AXI requires.
- Reset asserted mid-burst aborts immediately to the reset values. The partial write is kept in memory.
- len=0 is a single beat. len=255 INCR is supported, with no 4 KiB check.

## Structure
- Package `axi_mem_pkg`:
  - FSM state enum.
  - Burst encodings FIXED/INCR/WRAP.
  - Response encodings OKAY/SLVERR.
  - `AXI_ID_W=4`, `AXI_DATA_W=64`.
- Sub-module `axi_burst_addr`: combinational next-address generator (addr, size, len, burst → next addr). Shared by the read and write paths.
- Memory: an inferred single-port RAM with byte enables, inside the top module.

## Test plan
- Single write 64'hDEAD_BEEF_0123_4567 to 0x8000_0010 with WSTRB=8'hFF, then read it back. Expect BRESP=0 and RDATA equal to the written value with RLAST=1.
- INCR write len=7 from 0x8000_0100 with data i, then INCR read. Expect beats 0..7 in order and RLAST only on beat 7.
- WRAP read len=3, size=3, at 0x8000_0018. Expect addresses 0x18, 0x00, 0x08, 0x10 relative to the 32-byte block.
- Partial strobe: write 8'h0F over all-ones. Expect the readback to have upper 4 bytes 0xFF and lower 4 bytes equal to the new data.
- AWVALID and ARVALID together twice. Expect read granted first, then write. With RREADY held low for 5 cycles, RDATA stays stable.
- Write to 0x0000_1000 (out of range). Expect BRESP=2'b10 and memory unchanged. A read there returns RRESP=2'b10 with RDATA=0.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: shared AXI widths, FSM state, burst and response encodings for axi_mem_responder
package axi_mem_pkg;
  localparam int AXI_ID_W = 4;
  localparam int AXI_DATA_W = 64;
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_ISSUE, RD_DATA} state_e;
  typedef enum logic [1:0] {BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10} burst_e;
  typedef enum logic [1:0] {RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10} resp_e;
endpackage

// File: rtl/axi_mem_responder_if.sv
// axi_mem_responder_if: AXI4 AW/W/B/AR/R bundle; master drives address/data/ready-for-response, slave drives ready/response
interface axi_mem_responder_if;
  import axi_mem_pkg::*;
  logic [AXI_ID_W-1:0] awid;
  logic [63:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awlock;
  logic [3:0] awcache;
  logic [2:0] awprot;
  logic [3:0] awqos;
  logic awvalid;
  logic awready;
  logic [AXI_DATA_W-1:0] wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic wlast;
  logic wvalid;
  logic wready;
  logic [AXI_ID_W-1:0] bid;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  logic [AXI_ID_W-1:0] arid;
  logic [63:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arlock;
  logic [3:0] arcache;
  logic [2:0] arprot;
  logic [3:0] arqos;
  logic arvalid;
  logic arready;
  logic [AXI_ID_W-1:0] rid;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input awready,
    output wdata, wstrb, wlast, wvalid,
    input wready,
    input bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input arready,
    input rid, rdata, rresp, rlast, rvalid,
    output rready
  );
  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input bready,
    input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input rready
  );
endinterface

// File: rtl/axi_burst_addr.sv
// axi_burst_addr: combinational AXI next-beat address (in addr/size/len/burst, out nxt_addr); reserved burst acts as INCR
module axi_burst_addr import axi_mem_pkg::*; (
  input  logic [63:0] addr,
  input  logic [2:0]  size,
  input  logic [7:0]  len,
  input  logic [1:0]  burst,
  output logic [63:0] nxt_addr
);
  logic [63:0] step, mask, inc;
  always_comb begin
    step = 64'd1 << size;
    mask = ((64'(len) + 64'd1) << size) - 64'd1;
    inc = addr + step;
    nxt_addr = burst == BURST_FIXED ? addr : burst == BURST_WRAP ? (addr & ~mask) | (inc & mask) : inc;
  end
endmodule

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave over byte-enabled on-chip RAM (ports: clk_i, rst_ni async active-low, s = slave AXI bundle)
module axi_mem_responder import axi_mem_pkg::*; #(
  parameter int MEM_WORDS = 16384,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input logic clk_i,
  input logic rst_ni,
  axi_mem_responder_if.slave s
);
  localparam int IW = $clog2(MEM_WORDS);
  localparam logic [63:0] END_ADDR = BASE_ADDR + 64'(MEM_WORDS) * 64'd8;
  state_e st, st_n;
  logic last_wr, err_q, in_range, last_beat, grant_rd, aw_hs, ar_hs, w_hs, we, re;
  logic [AXI_ID_W-1:0] id_q;
  logic [63:0] addr_q, addr_nxt, ram_q;
  logic [7:0] len_q, cnt_q;
  logic [2:0] size_q;
  logic [1:0] burst_q;
  logic [IW-1:0] idx;
  logic [63:0] mem [MEM_WORDS];
  logic unused_ok;
  assign unused_ok = ^{s.awlock, s.awcache, s.awprot, s.awqos, s.arlock, s.arcache, s.arprot, s.arqos, s.wlast};
  assign idx = IW'((addr_q - BASE_ADDR) >> 3);
  assign in_range = addr_q >= BASE_ADDR && addr_q < END_ADDR;
  assign last_beat = cnt_q == len_q;
  assign grant_rd = s.arvalid && (!s.awvalid || last_wr);
  assign aw_hs = s.awvalid && s.awready;
  assign ar_hs = s.arvalid && s.arready;
  assign w_hs = s.wvalid && s.wready;
  assign we = w_hs && in_range;
  assign re = st == RD_ISSUE;
  axi_burst_addr u_addr (.addr(addr_q), .size(size_q), .len(len_q), .burst(burst_q), .nxt_addr(addr_nxt));
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) st <= IDLE;
    else st <= st_n;
  always_comb begin
    st_n = st;
    case (st)
      IDLE:     st_n = ar_hs ? RD_ISSUE : aw_hs ? WR_DATA : IDLE;
      WR_DATA:  st_n = w_hs && last_beat ? WR_RESP : WR_DATA;
      WR_RESP:  st_n = s.bready ? IDLE : WR_RESP;
      RD_ISSUE: st_n = RD_DATA;
      RD_DATA:  st_n = s.rready ? (last_beat ? IDLE : RD_ISSUE) : RD_DATA;
      default:  st_n = IDLE;
    endcase
  end
  always_comb begin
    s.awready = st == IDLE && s.awvalid && !grant_rd;
    s.arready = st == IDLE && grant_rd;
    s.wready = st == WR_DATA;
    s.bvalid = st == WR_RESP;
    s.bid = id_q;
    s.bresp = st == WR_RESP && err_q ? RESP_SLVERR : RESP_OKAY;
    s.rvalid = st == RD_DATA;
    s.rid = id_q;
    s.rdata = st == RD_DATA && !err_q ? ram_q : '0;
    s.rresp = st == RD_DATA && err_q ? RESP_SLVERR : RESP_OKAY;
    s.rlast = st == RD_DATA && last_beat;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      last_wr <= 1'b1;
      id_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      size_q <= '0;
      burst_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (aw_hs || ar_hs) begin
      last_wr <= aw_hs;
      id_q <= aw_hs ? s.awid : s.arid;
      addr_q <= aw_hs ? s.awaddr : s.araddr;
      len_q <= aw_hs ? s.awlen : s.arlen;
      size_q <= aw_hs ? s.awsize : s.arsize;
      burst_q <= aw_hs ? s.awburst : s.arburst;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (w_hs) begin
      addr_q <= addr_nxt;
      cnt_q <= cnt_q + 8'd1;
      err_q <= err_q | !in_range;
    end else if (re) begin
      err_q <= !in_range;
    end else if (st == RD_DATA && s.rready) begin
      addr_q <= addr_nxt;
      cnt_q <= cnt_q + 8'd1;
    end
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 8; b++)
      if (we && s.wstrb[b]) mem[idx][b*8 +: 8] <= s.wdata[b*8 +: 8];
    if (re) ram_q <= mem[idx];
  end
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: table-driven AXI transactions with a memory model and R/B scoreboard queues
module tb_axi_mem_responder;
  import axi_mem_pkg::*;
  localparam int WORDS = 16384;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] TOP = BASE + 64'(WORDS) * 64'd8;
  typedef struct { logic [3:0] id; logic [1:0] resp; logic [63:0] data; logic last; } r_exp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { bit wr; logic [63:0] addr; logic [7:0] len; logic [2:0] sz; logic [1:0] bt; logic [63:0] d0; logic [7:0] strb; logic [1:0] resp; } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  r_exp_t rq[$];
  b_exp_t bq[$];
  vec_t tbl[$];
  logic [63:0] mdl [logic [63:0]];
  always #5 clk = ~clk;
  axi_mem_responder_if bus();
  axi_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE)) dut (.clk_i(clk), .rst_ni(rst_n), .s(bus));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic bit in_rng(input logic [63:0] a);
    return a >= BASE && a < TOP;
  endfunction
  function automatic logic [63:0] tb_next(input logic [63:0] a, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bt);
    logic [63:0] step, total, lo, n;
    step = 64'd1 << sz;
    total = (64'(len) + 64'd1) * step;
    n = a + step;
    if (bt == BURST_FIXED) return a;
    if (bt == BURST_WRAP) begin
      lo = a - (a % total);
      if (n >= lo + total) n = n - total;
    end
    return n;
  endfunction
  function automatic void mwrite(input logic [63:0] a, input logic [63:0] d, input logic [7:0] st);
    logic [63:0] k, m;
    k = (a - BASE) >> 3;
    m = mdl.exists(k) ? mdl[k] : 64'h0;
    for (int b = 0; b < 8; b++) if (st[b]) m[b*8 +: 8] = d[b*8 +: 8];
    mdl[k] = m;
  endfunction
  function automatic logic [63:0] mread(input logic [63:0] a);
    logic [63:0] k;
    k = (a - BASE) >> 3;
    return mdl.exists(k) ? mdl[k] : 64'h0;
  endfunction
  function automatic vec_t mk(input bit wr, input logic [63:0] a, input logic [7:0] len, input logic [1:0] bt, input logic [63:0] d0, input logic [7:0] strb, input logic [1:0] resp);
    vec_t v;
    v.wr = wr; v.addr = a; v.len = len; v.sz = 3'd3; v.bt = bt; v.d0 = d0; v.strb = strb; v.resp = resp;
    return v;
  endfunction
  task automatic chk_reset(input string tag);
    chk({tag, "_ready_valid"}, 64'({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid}), 0);
    chk({tag, "_ids"}, 64'({bus.bid, bus.rid}), 0);
    chk({tag, "_resp"}, 64'({bus.bresp, bus.rresp, bus.rlast}), 0);
    chk({tag, "_rdata"}, bus.rdata, 0);
  endtask
  task automatic wr(input logic [3:0] id, input vec_t v);
    logic [63:0] aa;
    b_exp_t be;
    int n;
    aa = v.addr;
    be.id = id; be.resp = v.resp;
    bq.push_back(be);
    @(negedge clk);
    bus.awid = id; bus.awaddr = v.addr; bus.awlen = v.len; bus.awsize = v.sz; bus.awburst = v.bt; bus.awvalid = 1'b1;
    n = 0;
    #1;
    while (!bus.awready && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) chk("aw_timeout", 1, 0);
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(v.len); i++) begin
      bus.wdata = v.d0 + 64'(i); bus.wstrb = v.strb; bus.wlast = (i == int'(v.len)); bus.wvalid = 1'b1;
      if (i == 0) begin #1; chk("w_first_lat", 64'(bus.wready), 1); end
      if (in_rng(aa)) mwrite(aa, v.d0 + 64'(i), v.strb);
      aa = tb_next(aa, v.len, v.sz, v.bt);
      @(posedge clk);
      @(negedge clk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
    #1;
    chk("b_lat", 64'(bus.bvalid), 1);
    @(posedge clk);
    @(negedge clk);
    bus.bready = 1'b0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (rq.size() != 0 && n < 1200) begin @(negedge clk); n++; end
    if (n >= 1200) begin chk("r_timeout", 64'(rq.size()), 0); rq.delete(); end
    bus.rready = 1'b0;
  endtask
  task automatic rd(input logic [3:0] id, input vec_t v);
    logic [63:0] aa;
    r_exp_t re;
    int n;
    aa = v.addr;
    for (int i = 0; i <= int'(v.len); i++) begin
      re.id = id; re.resp = v.resp; re.data = v.resp == RESP_OKAY ? mread(aa) : 64'h0; re.last = (i == int'(v.len));
      rq.push_back(re);
      aa = tb_next(aa, v.len, v.sz, v.bt);
    end
    @(negedge clk);
    bus.arid = id; bus.araddr = v.addr; bus.arlen = v.len; bus.arsize = v.sz; bus.arburst = v.bt; bus.arvalid = 1'b1;
    n = 0;
    #1;
    while (!bus.arready && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) chk("ar_timeout", 1, 0);
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    #1;
    chk("r_issue", 64'(bus.rvalid), 0);
    @(negedge clk);
    #1;
    chk("r_lat", 64'(bus.rvalid), 1);
    drain();
  endtask
  always @(negedge clk) begin : mon
    r_exp_t re;
    b_exp_t be;
    #2;
    if (rst_n && bus.rvalid && bus.rready) begin
      if (rq.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        re = rq.pop_front();
        chk("rdata", bus.rdata, re.data);
        chk("rresp", 64'(bus.rresp), 64'(re.resp));
        chk("rlast", 64'(bus.rlast), 64'(re.last));
        chk("rid", 64'(bus.rid), 64'(re.id));
      end
    end
    if (rst_n && bus.bvalid && bus.bready) begin
      if (bq.size() == 0) chk("b_unexpected", 1, 0);
      else begin
        be = bq.pop_front();
        chk("bresp", 64'(bus.bresp), 64'(be.resp));
        chk("bid", 64'(bus.bid), 64'(be.id));
      end
    end
  end
  initial begin
    logic [63:0] old;
    r_exp_t re;
    b_exp_t be;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awlock = 1'b0; bus.awcache = '0; bus.awprot = '0; bus.awqos = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arlock = 1'b0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset("rst0");
    rst_n = 1'b1;
    tbl.push_back(mk(1, 64'h8000_0010, 0, BURST_INCR, 64'hDEAD_BEEF_0123_4567, 8'hFF, RESP_OKAY));
    tbl.push_back(mk(0, 64'h8000_0010, 0, BURST_INCR, 0, 0, RESP_OKAY));
    tbl.push_back(mk(1, 64'h8000_0100, 7, BURST_INCR, 64'h0, 8'hFF, RESP_OKAY));
    tbl.push_back(mk(0, 64'h8000_0100, 7, BURST_INCR, 0, 0, RESP_OKAY));
    tbl.push_back(mk(1, 64'h8000_0000, 3, BURST_INCR, 64'h100, 8'hFF, RESP_OKAY));
    tbl.push_back(mk(0, 64'h8000_0018, 3, BURST_WRAP, 0, 0, RESP_OKAY));
    tbl.push_back(mk(1, 64'h8000_0200, 0, BURST_INCR, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, RESP_OKAY));
    tbl.push_back(mk(1, 64'h8000_0200, 0, BURST_INCR, 64'h1122_3344_5566_7788, 8'h0F, RESP_OKAY));
    tbl.push_back(mk(0, 64'h8000_0200, 0, BURST_INCR, 0, 0, RESP_OKAY));
    tbl.push_back(mk(1, 64'h8000_1000, 0, BURST_INCR, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, RESP_OKAY));
    tbl.push_back(mk(1, 64'h0000_1000, 0, BURST_INCR, 64'h0, 8'hFF, RESP_SLVERR));
    tbl.push_back(mk(0, 64'h8000_1000, 0, BURST_INCR, 0, 0, RESP_OKAY));
    tbl.push_back(mk(0, 64'h0000_1000, 0, BURST_INCR, 0, 0, RESP_SLVERR));
    tbl.push_back(mk(1, 64'h8000_0300, 3, BURST_FIXED, 64'h30, 8'hFF, RESP_OKAY));
    tbl.push_back(mk(0, 64'h8000_0300, 1, BURST_FIXED, 0, 0, RESP_OKAY));
    tbl.push_back(mk(1, 64'h8001_FFF8, 1, BURST_INCR, 64'h77, 8'hFF, RESP_SLVERR));
    tbl.push_back(mk(0, 64'h8001_FFF8, 0, BURST_INCR, 0, 0, RESP_OKAY));
    tbl.push_back(mk(1, 64'h8000_1800, 255, BURST_INCR, 64'h5000, 8'hFF, RESP_OKAY));
    tbl.push_back(mk(0, 64'h8000_1800, 255, BURST_INCR, 0, 0, RESP_OKAY));
    tbl.push_back(mk(0, 64'h8000_0000, 3, BURST_WRAP, 0, 0, RESP_OKAY));
    for (int i = 0; i < tbl.size(); i++)
      if (tbl[i].wr) wr(4'(i), tbl[i]);
      else rd(4'(i), tbl[i]);
    @(negedge clk);
    bus.awid = 4'h3; bus.awaddr = 64'h8000_0500; bus.awlen = 8'd3; bus.awsize = 3'd3; bus.awburst = BURST_INCR; bus.awvalid = 1'b1;
    #1;
    chk("mid_awready", 64'(bus.awready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.wdata = 64'h70 + 64'(i); bus.wstrb = 8'hFF; bus.wvalid = 1'b1;
      mwrite(64'h8000_0500 + 64'(8 * i), 64'h70 + 64'(i), 8'hFF);
      @(posedge clk);
      @(negedge clk);
    end
    bus.wvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    old = mread(64'h8000_0010);
    re.id = 4'h6; re.resp = RESP_OKAY; re.data = old; re.last = 1'b1;
    rq.push_back(re);
    be.id = 4'h5; be.resp = RESP_OKAY;
    bq.push_back(be);
    @(negedge clk);
    bus.awid = 4'h5; bus.awaddr = 64'h8000_0010; bus.awlen = 8'd0; bus.awsize = 3'd3; bus.awburst = BURST_INCR; bus.awvalid = 1'b1;
    bus.arid = 4'h6; bus.araddr = 64'h8000_0010; bus.arlen = 8'd0; bus.arsize = 3'd3; bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
    #1;
    chk("arb1_arready", 64'(bus.arready), 1);
    chk("arb1_awready", 64'(bus.awready), 0);
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0; bus.rready = 1'b0;
    #1;
    chk("arb1_aw_wait", 64'(bus.awready), 0);
    @(negedge clk);
    #1;
    chk("stall_rvalid_rise", 64'(bus.rvalid), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("stall_rvalid", 64'(bus.rvalid), 1);
      chk("stall_rdata", bus.rdata, old);
      chk("stall_rlast", 64'(bus.rlast), 1);
    end
    bus.rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rready = 1'b0;
    mwrite(64'h8000_0010, 64'hCAFE_F00D_1234_5678, 8'hFF);
    re.id = 4'h7; re.data = 64'hCAFE_F00D_1234_5678;
    rq.push_back(re);
    bus.arid = 4'h7; bus.arvalid = 1'b1;
    #1;
    chk("arb2_awready", 64'(bus.awready), 1);
    chk("arb2_arready", 64'(bus.arready), 0);
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wdata = 64'hCAFE_F00D_1234_5678; bus.wstrb = 8'hFF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
    #1;
    chk("arb2_bvalid", 64'(bus.bvalid), 1);
    @(posedge clk);
    @(negedge clk);
    bus.bready = 1'b0;
    #1;
    chk("arb3_arready", 64'(bus.arready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    drain();
    rd(4'h9, mk(0, 64'h8000_0500, 1, BURST_INCR, 0, 0, RESP_OKAY));
    repeat (3) @(negedge clk);
    chk("rq_empty", 64'(rq.size()), 0);
    chk("bq_empty", 64'(bq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
